// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg: shared state encoding and helpers for the DAC streaming engine.
package dac_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [31:0] midscale(input int unsigned dw);
        return 32'd1 << (dw - 1);
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// dac_frame_fifo: synchronous show-ahead frame FIFO with occupancy count and almost flags.
module dac_frame_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       almst_full,
    output logic                       empty,
    output logic                       almst_empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr_ok, rd_ok;

    // A write while full is dropped even when a pop frees a slot that same cycle.
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign rd_data     = mem[rp];
    assign full        = count == CW'(DEPTH);
    assign almst_full  = count >= CW'(DEPTH - 2);
    assign empty       = count == '0;
    assign almst_empty = count <= CW'(2);

    always_ff @(posedge clk)
        if (wr_ok) mem[wp] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(wr_ok);
            rp    <= rp + AW'(rd_ok);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end

endmodule

// File: rtl/dac_stream_engine.sv
// dac_stream_engine: buffered multi-channel DAC streamer with start/stop control, hold or
// linear interpolation output (DAC_INTERP_EN selects interpolation), underrun/overflow flags.
module dac_stream_engine
    import dac_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 64,
    parameter int UPS_LOG2    = 4,
    parameter int PRIME_LEVEL = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clear_flags,
    input  logic                           wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
    output logic                           fifo_full,
    output logic                           fifo_almst_full,
    output logic                           fifo_empty,
    output logic                           fifo_almst_empty,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [NUM_CH*DATA_WIDTH-1:0]   dac_data_out,
    output logic                           dac_strobe,
    output logic                           dac_sleep_out,
    output logic                           underrun,
    output logic                           overflow,
    output logic [1:0]                     state_out
);
    localparam int FW = NUM_CH * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(midscale(DATA_WIDTH));

    state_t              state, state_nx;
    logic [UPS_LOG2-1:0] phase, phase_nx;
    logic [FW-1:0]       prev, cur, prev_nx, cur_nx, head, out_nx;
    logic                frame_tick, pop;

    dac_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (pop),
        .rd_data     (head),
        .full        (fifo_full),
        .almst_full  (fifo_almst_full),
        .empty       (fifo_empty),
        .almst_empty (fifo_almst_empty),
        .count       (fifo_count)
    );

    // stop freezes the pipeline in its cycle so the output holds exactly where it was.
    always_comb begin
        frame_tick = state == ST_RUN && &phase && !stop;
        pop        = frame_tick && !fifo_empty;
        state_nx   = stop                                            ? ST_IDLE  :
                     (state == ST_IDLE && start)                     ? ST_PRIME :
                     (state == ST_PRIME && fifo_count >= CW'(PRIME_LEVEL)) ? ST_RUN :
                     (frame_tick && fifo_empty)                      ? ST_PRIME : state;
        phase_nx   = (state != ST_RUN && state_nx == ST_RUN) ? '1 :
                     (state == ST_RUN && !stop)             ? phase + 1'b1 : phase;
        prev_nx    = frame_tick ? cur : prev;
        cur_nx     = pop ? head : cur;
    end

`ifdef DAC_INTERP_EN
    localparam int PW = DATA_WIDTH + 1 + UPS_LOG2;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_interp
        localparam int L = ch_lsb(c, DATA_WIDTH);
        logic signed [PW-1:0] p0, d, p;
        assign p0 = $signed({{(PW-DATA_WIDTH){1'b0}}, prev_nx[L +: DATA_WIDTH]});
        assign d  = $signed({{(PW-DATA_WIDTH){1'b0}}, cur_nx[L +: DATA_WIDTH]}) - p0;
        assign p  = $signed({{(PW-UPS_LOG2){1'b0}}, phase_nx});
        // The interpolant never leaves [prev, cur], so the low bits are the exact code.
        assign out_nx[L +: DATA_WIDTH] = DATA_WIDTH'(p0 + ((d * p) >>> UPS_LOG2));
    end
`else
    assign out_nx = cur_nx;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= ST_IDLE;
            phase        <= '0;
            prev         <= {NUM_CH{MID}};
            cur          <= {NUM_CH{MID}};
            dac_data_out <= {NUM_CH{MID}};
            dac_strobe   <= 1'b0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nx;
            phase        <= phase_nx;
            prev         <= prev_nx;
            cur          <= cur_nx;
            dac_data_out <= out_nx;
            dac_strobe   <= pop;
            underrun     <= (frame_tick && fifo_empty) || (underrun && !clear_flags);
            overflow     <= (wr_en && fifo_full) || (overflow && !clear_flags);
        end

    assign dac_sleep_out = state == ST_IDLE;
    assign state_out     = state;

endmodule

// File: tb/tb_dac_stream_engine.sv
// tb_dac_stream_engine: scoreboard bench; written frames are queued and checked at each dac_strobe.
module tb_dac_stream_engine;
    localparam int DW = 14;
    localparam int FW = 28;
    localparam logic [FW-1:0] MIDF = {14'h2000, 14'h2000};

    logic          clk, rst_n, start, stop, clear_flags, wr_en;
    logic [FW-1:0] wr_data, dac_data_out;
    logic          fifo_full, fifo_almst_full, fifo_empty, fifo_almst_empty;
    logic [6:0]    fifo_count;
    logic          dac_strobe, dac_sleep_out, underrun, overflow;
    logic [1:0]    state_out;

    int compared = 0;
    int mismatched = 0;
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] last, held;
    int n;

    dac_stream_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear_flags(clear_flags),
        .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full),
        .fifo_almst_full(fifo_almst_full), .fifo_empty(fifo_empty),
        .fifo_almst_empty(fifo_almst_empty), .fifo_count(fifo_count),
        .dac_data_out(dac_data_out), .dac_strobe(dac_strobe), .dac_sleep_out(dac_sleep_out),
        .underrun(underrun), .overflow(overflow), .state_out(state_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] frame(input int i);
        return {14'(i * 3 + 100), 14'(i * 7 + 5)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [FW-1:0] f, input bit push);
        wr_en = 1;
        wr_data = f;
        tick();
        wr_en = 0;
        if (push) sb_q.push_back(f);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string name);
        int k = 0;
        while (state_out !== s && k < lim) begin
            tick();
            k++;
        end
        chk(name, state_out, s);
    endtask

    task automatic wait_strobe(input string name, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!dac_strobe && cnt < 40);
        chk(name, dac_strobe, 1);
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // Hold mode shows each frame at its strobe; interpolation shows the previous frame.
    always @(negedge clk) begin
        logic [FW-1:0] f, exp;
        if (!rst_n) last = MIDF;
        else if (dac_strobe) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL strobe_unexpected: got %0h expected no strobe", dac_data_out);
            end else begin
                f = sb_q.pop_front();
`ifdef DAC_INTERP_EN
                exp = last;
`else
                exp = f;
`endif
                last = f;
                chk("strobe_data", dac_data_out, exp);
            end
        end
    end

    initial begin
        rst_n = 0; start = 0; stop = 0; clear_flags = 0; wr_en = 0; wr_data = '0;
        #12;
        chk("rst_data", dac_data_out, MIDF);
        chk("rst_state", state_out, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_sleep", dac_sleep_out, 1);
        chk("rst_strobe", dac_strobe, 0);
        chk("rst_flags", {underrun, overflow}, 0);
        chk("rst_empty", {fifo_empty, fifo_almst_empty}, 2'b11);
        tick();
        rst_n = 1;
        tick();

        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("startstop_state", state_out, 0);
        chk("startstop_sleep", dac_sleep_out, 1);

        for (int i = 0; i < 40; i++) wr(frame(i), 1);
        chk("preload_count", fifo_count, 40);
        chk("preload_flags", {fifo_full, fifo_almst_full, fifo_empty, fifo_almst_empty}, 0);
        pulse_start();
        chk("prime_state", state_out, 1);
        chk("prime_sleep", dac_sleep_out, 0);
        tick();
        chk("run_state", state_out, 2);
        tick();
        chk("first_strobe", dac_strobe, 1);
`ifndef DAC_INTERP_EN
        chk("first_data", dac_data_out, frame(0));
`endif
        wait_strobe("strobe_2", n);
        chk("strobe_period", n, 16);

        wait_state(1, 1000, "underrun_prime");
        chk("underrun_flag", underrun, 1);
        chk("underrun_hold", dac_data_out, frame(39));
        chk("sb_drained", sb_q.size(), 0);

        for (int i = 0; i < 32; i++) wr(frame(100 + i), 1);
        wait_state(2, 10, "resume_run");
        clear_flags = 1;
        tick();
        clear_flags = 0;
        chk("underrun_clear", underrun, 0);
        wait_strobe("resume_strobe_a", n);
        wait_strobe("resume_strobe_b", n);
        chk("resume_period", n, 16);
        repeat (5) tick();
        stop = 1;
        tick();
        stop = 0;
        held = dac_data_out;
        chk("stop_state", state_out, 0);
        chk("stop_sleep", dac_sleep_out, 1);
        repeat (20) tick();
        chk("stop_hold", dac_data_out, held);

        for (int i = 0; i < 8; i++) wr(frame(200 + i), 1);
        pulse_start();
        wait_state(2, 10, "restart_run");
        wait_strobe("restart_strobe_a", n);
        wait_strobe("restart_strobe_b", n);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_data", dac_data_out, MIDF);
        chk("arst_state", state_out, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_strobe_sleep", {dac_strobe, dac_sleep_out}, 2'b01);
        sb_q.delete();
        tick();
        rst_n = 1;
        tick();

`ifdef DAC_INTERP_EN
        wr({14'h0, 14'h0}, 1);
        for (int i = 0; i < 31; i++) wr({14'h0, 14'h100}, 1);
        pulse_start();
        wait_strobe("ramp_strobe_a", n);
        wait_strobe("ramp_strobe_b", n);
        chk("ramp_0", dac_data_out[DW-1:0], 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("ramp_step", dac_data_out[DW-1:0], 64'(k * 16));
        end
        rst_n = 0;
        tick();
        sb_q.delete();
        rst_n = 1;
        tick();
`endif

        for (int i = 0; i < 65; i++) wr(frame(300 + i), 0);
        chk("ovf_count", fifo_count, 64);
        chk("ovf_full", {fifo_full, fifo_almst_full, fifo_empty}, 3'b110);
        chk("ovf_flag", overflow, 1);
        clear_flags = 1;
        tick();
        clear_flags = 0;
        chk("ovf_clear", overflow, 0);
        clear_flags = 1;
        wr_en = 1;
        tick();
        clear_flags = 0;
        wr_en = 0;
        chk("ovf_event_wins", overflow, 1);
        chk("ovf_count_kept", fifo_count, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
